// File: rtl/multicycle_control_unit_if.sv
// Bus between the multi-cycle control unit and its fetch / ALU / regfile / PC neighbours.
// slave = control unit side, master = environment side.
interface multicycle_control_unit_if #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 6,
  parameter int REG_W   = 3
);
  localparam int IMM_W = INSTR_W - OPC_W - REG_W - 2;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic               alu_done;
  logic               alu_zero;
  logic               alu_carry;
  logic [5:0]         alucode;
  logic               imControl;
  logic               alu_start;
  logic               writecode;
  logic [2:0]         pcControl;
  logic               pc_update;
  logic [REG_W-1:0]   op1;
  logic [IMM_W-1:0]   op2;
  logic               flag;
  logic               flag1;
  logic               halted;
  logic               illegal;

  modport slave (
    input  instr_valid, instruction, alu_done, alu_zero, alu_carry,
    output instr_ready, alucode, imControl, alu_start, writecode, pcControl,
           pc_update, op1, op2, flag, flag1, halted, illegal
  );

  modport master (
    output instr_valid, instruction, alu_done, alu_zero, alu_carry,
    input  instr_ready, alucode, imControl, alu_start, writecode, pcControl,
           pc_update, op1, op2, flag, flag1, halted, illegal
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXECUTE/WRITEBACK sequencer with variable-latency ALU ops,
// flag-conditional jumps and a sticky HALT state.
module multicycle_control_unit #(
  parameter int INSTR_W = 32,
  parameter int OPC_W   = 6,
  parameter int REG_W   = 3,
  parameter int MC_EN   = 1
) (
  input logic clock,
  input logic reset,
  multicycle_control_unit_if.slave bus
);
  localparam int IMM_W = INSTR_W - OPC_W - REG_W - 2;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t             state, nxt;
  logic [INSTR_W-1:0] ir;
  logic [OPC_W-1:0]   opc;
  int unsigned        oc;
  logic               zf, cf;
  logic               hs;
  logic               is_arith, is_jump, is_mov, is_nop, is_hlt, is_ill, is_mc, taken;
  logic [5:0]         alucode_n;
  logic               imc_n;
  logic               start_d, wc_d, pcu_d, halted_d, illegal_d;
  logic [2:0]         pcc_d;

  assign opc             = ir[INSTR_W-1 -: OPC_W];
  assign oc              = 32'(opc);
  assign bus.instr_ready = (state == S_FETCH) && reset;
  assign hs              = bus.instr_valid && bus.instr_ready;

  always_comb begin
    is_arith = (oc <= 32'd14);
    is_jump  = (oc >= 32'd15) && (oc <= 32'd23);
    is_mov   = (oc == 32'd24);
    is_nop   = (oc == 32'd25);
    is_hlt   = (oc == 32'd26);
    is_ill   = (oc > 32'd26);
    is_mc    = (MC_EN != 0) && (oc == 32'd2 || oc == 32'd3 || oc == 32'd6 ||
                                oc == 32'd7 || oc == 32'd12);
    // zf/cf here are from earlier instructions; this one's flags land only in its own WB
    taken = 1'b0;
    case (oc)
      32'd15:         taken = 1'b1;
      32'd16, 32'd22: taken = zf;
      32'd19, 32'd23: taken = !zf;
      32'd17:         taken = cf;
      32'd21:         taken = !cf;
      32'd18:         taken = !cf && !zf;
      32'd20:         taken = cf || zf;
      default:        taken = 1'b0;
    endcase
    alucode_n = 6'd0;
    case (oc)
      32'd0, 32'd4: alucode_n = 6'd1;
      32'd1, 32'd5: alucode_n = 6'd2;
      32'd2, 32'd6: alucode_n = 6'd3;
      32'd3, 32'd7: alucode_n = 6'd4;
      32'd8:        alucode_n = 6'd5;
      32'd9:        alucode_n = 6'd6;
      32'd10:       alucode_n = 6'd7;
      32'd11:       alucode_n = 6'd8;
      32'd12:       alucode_n = 6'd9;
      32'd13:       alucode_n = 6'd10;
      32'd14:       alucode_n = 6'd11;
      32'd24:       alucode_n = 6'd12;
      default:      alucode_n = 6'd0;
    endcase
    if (oc >= 32'd4 && oc <= 32'd7)                    imc_n = 1'b1;
    else if ((oc >= 32'd8 && oc <= 32'd14) || is_mov) imc_n = ir[IMM_W];
    else                                               imc_n = 1'b0;
  end

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state <= S_FETCH;
    else        state <= nxt;
  end

  // next-state
  always_comb begin
    nxt = state;
    unique case (state)
      S_FETCH:  if (hs) nxt = S_DECODE;
      S_DECODE: nxt = (is_ill || is_hlt) ? S_HALT : S_EXEC;
      S_EXEC:   if (!(is_mc && !bus.alu_done)) nxt = S_WB;
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_FETCH;
    endcase
  end

  // outputs: computed one cycle ahead so every control output is a flop
  always_comb begin
    start_d   = 1'b0;
    wc_d      = 1'b0;
    pcu_d     = 1'b0;
    pcc_d     = bus.pcControl;
    halted_d  = bus.halted;
    illegal_d = bus.illegal;
    unique case (state)
      S_DECODE: begin
        if (is_ill || is_hlt) begin
          pcu_d     = 1'b1;
          pcc_d     = 3'd2;
          halted_d  = 1'b1;
          illegal_d = bus.illegal | is_ill;
        end else begin
          start_d = !(is_jump || is_nop);
        end
      end
      S_EXEC: begin
        if (nxt == S_WB) begin
          wc_d  = is_arith || is_mov;
          pcu_d = 1'b1;
          pcc_d = {2'b00, taken};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ir            <= '0;
      zf            <= 1'b0;
      cf            <= 1'b0;
      bus.alucode   <= '0;
      bus.imControl <= 1'b0;
      bus.op1       <= '0;
      bus.op2       <= '0;
      bus.flag      <= 1'b0;
      bus.flag1     <= 1'b0;
      bus.alu_start <= 1'b0;
      bus.writecode <= 1'b0;
      bus.pcControl <= '0;
      bus.pc_update <= 1'b0;
      bus.halted    <= 1'b0;
      bus.illegal   <= 1'b0;
    end else begin
      if (hs) ir <= bus.instruction;
      if (state == S_WB && is_arith) begin
        zf <= bus.alu_zero;
        cf <= bus.alu_carry;
      end
      if (state == S_DECODE) begin
        bus.alucode   <= alucode_n;
        bus.imControl <= imc_n;
        bus.op1       <= ir[INSTR_W-OPC_W-2 -: REG_W];
        bus.op2       <= ir[IMM_W-1:0];
        bus.flag      <= ir[INSTR_W-OPC_W-1];
        bus.flag1     <= ir[IMM_W];
      end
      bus.alu_start <= start_d;
      bus.writecode <= wc_d;
      bus.pcControl <= pcc_d;
      bus.pc_update <= pcu_d;
      bus.halted    <= halted_d;
      bus.illegal   <= illegal_d;
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: a transaction-level model schedules expected outputs per cycle
// and every cycle is compared at the falling edge.
module tb_multicycle_control_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multicycle_control_unit_if bus ();
  multicycle_control_unit dut (.clock(clock), .reset(reset), .bus(bus));

  int errors = 0, checks = 0;
  // model state
  logic       m_zf = 0, m_cf = 0;
  logic [5:0] e_alucode = 0;
  logic       e_imc = 0, e_flag = 0, e_flag1 = 0, e_halted = 0, e_illegal = 0;
  logic       e_ready = 0, e_start = 0, e_wc = 0, e_pcu = 0;
  logic [2:0] e_op1 = 0, e_pcc = 0;
  logic [20:0] e_op2 = 0;
  bit         chk_en = 0;
  int cur_k = 0, n_start = 0, n_wc = 0, n_pcu = 0, start_k = -1, wc_k = -1;
  int b_start = 0, b_wc = 0, b_pcu = 0;
  logic [2:0] pcc_at_pcu = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] m_alucode(input int o);
    case (o)
      0, 4: return 6'd1;   1, 5: return 6'd2;   2, 6: return 6'd3;  3, 7: return 6'd4;
      8: return 6'd5;      9: return 6'd6;      10: return 6'd7;    11: return 6'd8;
      12: return 6'd9;     13: return 6'd10;    14: return 6'd11;   24: return 6'd12;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic m_imc(input int o, input logic f1);
    if (o >= 4 && o <= 7) return 1'b1;
    if ((o >= 8 && o <= 14) || o == 24) return f1;
    return 1'b0;
  endfunction

  function automatic logic m_taken(input int o, input logic z, input logic c);
    case (o)
      15: return 1'b1;
      16, 22: return z;
      19, 23: return !z;
      17: return c;
      21: return !c;
      18: return !c && !z;
      20: return c || z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input int o, input logic f, input int r, input logic f1, input int imm);
    logic [5:0]  ob;
    logic [2:0]  rb;
    logic [20:0] ib;
    ob = 6'(o); rb = 3'(r); ib = 21'(imm);
    return {ob, f, rb, f1, ib};
  endfunction

  task automatic clear_model();
    m_zf = 0; m_cf = 0; e_alucode = 0; e_imc = 0; e_flag = 0; e_flag1 = 0;
    e_halted = 0; e_illegal = 0; e_start = 0; e_wc = 0; e_pcu = 0; e_op1 = 0; e_op2 = 0; e_pcc = 0;
  endtask

  task automatic compare_outputs();
    chk("instr_ready", 32'(bus.instr_ready), 32'(e_ready));
    chk("alu_start",   32'(bus.alu_start),   32'(e_start));
    chk("writecode",   32'(bus.writecode),   32'(e_wc));
    chk("pc_update",   32'(bus.pc_update),   32'(e_pcu));
    chk("alucode",     32'(bus.alucode),     32'(e_alucode));
    chk("imControl",   32'(bus.imControl),   32'(e_imc));
    chk("op1",         32'(bus.op1),         32'(e_op1));
    chk("op2",         32'(bus.op2),         32'(e_op2));
    chk("flag",        32'(bus.flag),        32'(e_flag));
    chk("flag1",       32'(bus.flag1),       32'(e_flag1));
    chk("halted",      32'(bus.halted),      32'(e_halted));
    chk("illegal",     32'(bus.illegal),     32'(e_illegal));
    if (e_pcu || e_halted) chk("pcControl", 32'(bus.pcControl), 32'(e_pcc));
    if (bus.alu_start === 1'b1) begin n_start++; start_k = cur_k; end
    if (bus.writecode === 1'b1) begin n_wc++; wc_k = cur_k; end
    if (bus.pc_update === 1'b1) begin n_pcu++; pcc_at_pcu = bus.pcControl; end
  endtask

  task automatic step();
    @(negedge clock);
    if (chk_en) compare_outputs();
    @(posedge clock);
    #1;
  endtask

  // Issues one instruction at the current FETCH cycle (k=0) and walks it to completion.
  task automatic run(input logic [31:0] ins, input int done_at, input logic z, input logic c,
                     input int abort_at);
    int o, wb;
    logic ar, jp, mc, hl, il, startable, wr;
    o  = int'(ins[31:26]);
    ar = (o <= 14); jp = (o >= 15 && o <= 23);
    mc = (o == 2 || o == 3 || o == 6 || o == 7 || o == 12);
    hl = (o == 26); il = (o > 26);
    startable = !jp && (o != 25);
    wr = ar || (o == 24);
    b_start = n_start; b_wc = n_wc; b_pcu = n_pcu; start_k = -1; wc_k = -1;

    cur_k = 0; bus.instr_valid = 1; bus.instruction = ins; bus.alu_done = 0;
    e_ready = 1; e_start = 0; e_wc = 0; e_pcu = 0;
    step();
    // garbage word and an early alu_done while not in FETCH/EXECUTE must be ignored
    cur_k = 1; bus.instruction = $urandom; bus.alu_done = 1; e_ready = 0;
    step();
    bus.alu_done = 0; cur_k = 2;
    e_alucode = m_alucode(o); e_imc = m_imc(o, ins[21]);
    e_op1 = ins[24:22]; e_op2 = ins[20:0]; e_flag = ins[25]; e_flag1 = ins[21];
    if (hl || il) begin
      e_halted = 1; e_illegal = e_illegal | il; e_pcu = 1; e_pcc = 3'd2;
      step();
      e_pcu = 0;
      for (int k = 3; k < 8; k++) begin cur_k = k; step(); end
      bus.instr_valid = 0;
      return;
    end
    wb = mc ? done_at + 1 : 3;
    for (int k = 2; k < wb; k++) begin
      cur_k = k; e_start = (k == 2) && startable; bus.alu_done = mc && (k == done_at);
      if (k == abort_at) reset = 0;
      step();
      if (k == abort_at) begin
        reset = 1; bus.instr_valid = 0; bus.alu_done = 0;
        clear_model(); e_ready = 1;
        return;
      end
    end
    cur_k = wb; bus.alu_done = 0; e_start = 0; e_wc = wr; e_pcu = 1;
    e_pcc = {2'b00, m_taken(o, m_zf, m_cf)}; bus.alu_zero = z; bus.alu_carry = c;
    step();
    if (ar) begin m_zf = z; m_cf = c; end
    e_wc = 0; e_pcu = 0; e_ready = 1; bus.instr_valid = 0; cur_k = wb + 1;
  endtask

  task automatic do_reset();
    reset = 0; e_ready = 0;
    step();
    reset = 1; clear_model(); e_ready = 1;
  endtask

  initial begin
    bus.instr_valid = 0; bus.instruction = 0; bus.alu_done = 0;
    bus.alu_zero = 0; bus.alu_carry = 0;
    @(posedge clock); #1;
    chk_en = 1;
    step();
    reset = 1; e_ready = 1;
    chk("rst_alucode", 32'(bus.alucode), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);

    // idle FETCH: nothing moves
    b_pcu = n_pcu;
    for (int i = 0; i < 10; i++) step();
    chk("idle_pcu", 32'(n_pcu - b_pcu), 32'd0);

    // ADDI r2,#5
    run(mk(4, 0, 2, 0, 5), 0, 0, 0, -1);
    chk("addi_alucode", 32'(bus.alucode), 32'd1);
    chk("addi_imc", 32'(bus.imControl), 32'd1);
    chk("addi_op1", 32'(bus.op1), 32'd2);
    chk("addi_op2", 32'(bus.op2), 32'd5);
    chk("addi_start_k", 32'(start_k), 32'd2);
    chk("addi_wc_k", 32'(wc_k), 32'd3);
    chk("addi_pcc", 32'(pcc_at_pcu), 32'd0);
    chk("addi_ready4", 32'(bus.instr_ready), 32'd1);

    // MUL with alu_done at +7
    run(mk(2, 0, 1, 0, 3), 7, 0, 0, -1);
    chk("mul_wc_k", 32'(wc_k), 32'd8);
    chk("mul_starts", 32'(n_start - b_start), 32'd1);
    chk("mul_alucode", 32'(bus.alucode), 32'd3);

    // SUB sets zf, JE taken, JNE not
    run(mk(1, 0, 3, 0, 0), 0, 1, 0, -1);
    run(mk(16, 0, 0, 0, 'h40), 0, 0, 0, -1);
    chk("je_pcc", 32'(pcc_at_pcu), 32'd1);
    chk("je_op2", 32'(bus.op2), 32'h40);
    chk("je_wc", 32'(n_wc - b_wc), 32'd0);
    run(mk(19, 0, 0, 0, 'h80), 0, 0, 0, -1);
    chk("jne_pcc", 32'(pcc_at_pcu), 32'd0);

    // ADD leaves zf=0 cf=1
    run(mk(0, 0, 1, 0, 2), 0, 0, 1, -1);
    run(mk(18, 0, 0, 0, 'h11), 0, 0, 0, -1);
    chk("ja_pcc", 32'(pcc_at_pcu), 32'd0);
    run(mk(20, 0, 0, 0, 'h12), 0, 0, 0, -1);
    chk("jbe_pcc", 32'(pcc_at_pcu), 32'd1);
    run(mk(21, 0, 0, 0, 'h13), 0, 0, 0, -1);
    run(mk(17, 0, 0, 0, 'h14), 0, 0, 0, -1);
    // MOV must not touch flags
    run(mk(24, 0, 4, 1, 7), 0, 1, 0, -1);
    chk("mov_alucode", 32'(bus.alucode), 32'd12);
    chk("mov_imc", 32'(bus.imControl), 32'd1);
    run(mk(22, 0, 0, 0, 'h15), 0, 0, 0, -1);
    chk("jz_after_mov", 32'(pcc_at_pcu), 32'd0);
    run(mk(15, 0, 0, 0, 'h16), 0, 0, 0, -1);
    run(mk(25, 0, 0, 0, 0), 0, 0, 0, -1);
    chk("nop_starts", 32'(n_start - b_start), 32'd0);
    run(mk(8, 1, 5, 1, 0), 0, 1, 0, -1);
    run(mk(20, 0, 0, 0, 'h17), 0, 0, 0, -1);
    run(mk(11, 0, 6, 0, 9), 0, 0, 0, -1);

    // DIV aborted by reset during EXECUTE
    run(mk(3, 0, 2, 0, 4), 9, 0, 0, 3);
    chk("abort_wc", 32'(n_wc - b_wc), 32'd0);
    chk("abort_pcu", 32'(n_pcu - b_pcu), 32'd0);
    step();
    chk("abort_alucode", 32'(bus.alucode), 32'd0);

    // illegal opcode
    run(mk(40, 0, 1, 0, 1), 0, 0, 0, -1);
    chk("ill_illegal", 32'(bus.illegal), 32'd1);
    chk("ill_halted", 32'(bus.halted), 32'd1);
    chk("ill_ready", 32'(bus.instr_ready), 32'd0);
    chk("ill_wc", 32'(n_wc - b_wc), 32'd0);
    do_reset();
    chk("ill_rst_illegal", 32'(bus.illegal), 32'd0);
    chk("ill_rst_halted", 32'(bus.halted), 32'd0);

    // HLT
    run(mk(26, 0, 0, 0, 0), 0, 0, 0, -1);
    chk("hlt_pcu_cnt", 32'(n_pcu - b_pcu), 32'd1);
    chk("hlt_pcc", 32'(bus.pcControl), 32'd2);
    chk("hlt_illegal", 32'(bus.illegal), 32'd0);
    do_reset();
    run(mk(5, 0, 7, 0, 3), 0, 0, 0, -1);
    for (int i = 0; i < 3; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
